// File: rtl/gfx_pkg.sv
// Shared graphics constants: window geometry, line buffer word layout and the
// scanout line-state encoding.
package gfx_pkg;

  localparam int WIN_W = 320;
  localparam int WIN_H = 200;

  typedef struct packed {
    logic [2:0] palette;
    logic [3:0] color;
  } linebuf_word_t;

  typedef enum logic {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } line_state_t;

endpackage

// File: rtl/gfx_scanout_if.sv
// Scanout bus: display timing in, render request / line buffer port to gfx,
// pixel stream out. border_color exists only with GFX_SCANOUT_BORDER_EN.
interface gfx_scanout_if;
  import gfx_pkg::*;

  logic          pix_en;
  logic          line_start;
  logic [8:0]    vpos;
  logic          hactive;
  logic [7:0]    vline;
  logic          start;
  logic [8:0]    linebuf_rdidx;
  linebuf_word_t linebuf_data;
  logic          pix_valid;
  logic [6:0]    pix_data;
  logic          pix_border;
  logic          pix_opaque;
`ifdef GFX_SCANOUT_BORDER_EN
  logic [6:0]    border_color;
`endif

  modport master (
    input  pix_en, line_start, vpos, hactive, linebuf_data,
`ifdef GFX_SCANOUT_BORDER_EN
    input  border_color,
`endif
    output vline, start, linebuf_rdidx,
    output pix_valid, pix_data, pix_border, pix_opaque
  );

  modport slave (
    output pix_en, line_start, vpos, hactive, linebuf_data,
`ifdef GFX_SCANOUT_BORDER_EN
    output border_color,
`endif
    input  vline, start, linebuf_rdidx,
    input  pix_valid, pix_data, pix_border, pix_opaque
  );

endinterface

// File: rtl/gfx_scanout.sv
// Scanout of the 320x200 graphics window: render requests one line ahead and a
// 2-clk pixel pipeline through the line buffer. Option: GFX_SCANOUT_BORDER_EN.
module gfx_scanout
  import gfx_pkg::*;
#(
  parameter int VSTART = 20,
  parameter int HSTART = 16
) (
  input  logic          clk,
  input  logic          reset,
  gfx_scanout_if.master bus
);

  localparam logic [9:0] V_FIRST = 10'(VSTART);
  localparam logic [9:0] V_LAST  = 10'(VSTART + WIN_H - 1);
  localparam logic [9:0] H_FIRST = 10'(HSTART);
  localparam logic [9:0] H_END   = 10'(HSTART + WIN_W);

  // ---------------------------------------------------------------- render
  logic [9:0]  next_line;
  logic        render_req;
  logic        render_pending;
  logic        start_q;
  logic [7:0]  vline_q;

  assign next_line  = {1'b0, bus.vpos} + 10'd1;
  assign render_req = bus.line_start && (next_line >= V_FIRST) && (next_line <= V_LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      start_q        <= 1'b0;
      vline_q        <= 8'd0;
      render_pending <= 1'b0;
    end else begin
      start_q <= render_req;
      if (render_req)     vline_q        <= 8'(next_line - V_FIRST);
      if (bus.line_start) render_pending <= render_req;
    end
  end

  // ------------------------------------------------------------ line FSM
  line_state_t state, state_nxt;
  logic        show_line;

  always_ff @(posedge clk) begin
    if (reset) state <= ST_BLANK;
    else       state <= state_nxt;
  end

  // NOTE: default assignment first so no path through the block leaves
  // state_nxt unassigned, which would infer a latch.
  always_comb begin
    state_nxt = state;
    if (bus.line_start) state_nxt = render_pending ? ST_SHOW : ST_BLANK;
  end

  always_comb begin
    show_line = (state == ST_SHOW);
  end

  // ------------------------------------------------------- column counter
  logic [8:0] hcol;
  logic [8:0] hcol_s;
  logic       pix_take;
  logic       in_win_s;

  // A pixel arriving with line_start belongs to column 0 of the new line.
  assign hcol_s   = bus.line_start ? 9'd0 : hcol;
  assign pix_take = bus.pix_en && bus.hactive;
  assign in_win_s = ({1'b0, hcol_s} >= H_FIRST) && ({1'b0, hcol_s} < H_END);

  always_ff @(posedge clk) begin
    if (reset)                              hcol <= 9'd0;
    else if (bus.line_start)                hcol <= 9'd0;
    else if (pix_take && hcol != 9'd511)    hcol <= hcol + 9'd1;
  end

  // ------------------------------------------------------- pixel pipeline
  logic       s1_valid, s1_in_win;
  logic       s2_valid, s2_in_win;
  logic [8:0] rdidx_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid  <= 1'b0;
      s1_in_win <= 1'b0;
      rdidx_q   <= 9'd0;
      s2_valid  <= 1'b0;
      s2_in_win <= 1'b0;
    end else begin
      s1_valid <= pix_take;
      if (pix_take) begin
        rdidx_q   <= hcol_s - 9'(HSTART);
        s1_in_win <= in_win_s && show_line;
      end
      s2_valid  <= s1_valid;
      s2_in_win <= s1_valid && s1_in_win;
    end
  end

  // The line buffer returns data in the cycle where s2 is valid, so the pixel
  // fields are formed from it directly rather than through another register.
  logic [6:0] border_val;
`ifdef GFX_SCANOUT_BORDER_EN
  assign border_val = bus.border_color;
`else
  assign border_val = 7'd0;
`endif

  assign bus.start         = start_q;
  assign bus.vline         = vline_q;
  assign bus.linebuf_rdidx = rdidx_q;
  assign bus.pix_valid     = s2_valid;
  assign bus.pix_border    = s2_valid && !s2_in_win;
  assign bus.pix_opaque    = s2_in_win && (bus.linebuf_data.color != 4'd0);
  assign bus.pix_data      = !s2_valid ? 7'd0 :
                             s2_in_win ? bus.linebuf_data : border_val;

endmodule

// File: tb/tb_gfx_scanout.sv
// Directed bench for gfx_scanout: table of per-pixel vectors plus hand-written
// reset, hactive and line_start/pix_en corner sequences.
module tb_gfx_scanout;
  import gfx_pkg::*;

`ifdef GFX_SCANOUT_BORDER_EN
  localparam logic [6:0] BORDER = 7'h12;
`else
  localparam logic [6:0] BORDER = 7'h00;
`endif

  logic clk = 1'b0;
  logic reset;
  gfx_scanout_if bus ();

  gfx_scanout #(.VSTART(20), .HSTART(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Line buffer model: registered read, data one clk after the index.
  logic [6:0] lb_mem [512];
  always @(posedge clk) bus.linebuf_data <= lb_mem[bus.linebuf_rdidx];

  int n_vec = 0;
  int n_err = 0;
  int cur_col = 0;

  typedef struct {
    bit         new_line;
    logic [8:0] vpos;
    bit         exp_start;
    logic [7:0] exp_vline;
    int         col;
    logic [8:0] exp_idx;
    bit         exp_border;
    logic [6:0] exp_data;
    bit         exp_opaque;
  } vec_t;

  vec_t vecs [11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_line(input logic [8:0] v, input bit exp_start, input logic [7:0] exp_vline);
    bus.line_start = 1'b1;
    bus.vpos       = v;
    tick();
    check($sformatf("start@vpos%0d", v), 32'(bus.start), 32'(exp_start));
    check($sformatf("vline@vpos%0d", v), 32'(bus.vline), 32'(exp_vline));
    bus.line_start = 1'b0;
    tick();
    check($sformatf("start_drop@vpos%0d", v), 32'(bus.start), 32'd0);
    cur_col = 0;
  endtask

  task automatic advance(input int n);
    for (int k = 0; k < n; k++) begin
      bus.pix_en  = 1'b1;
      bus.hactive = 1'b1;
      tick();
    end
    bus.pix_en = 1'b0;
  endtask

  task automatic pixel_check(input string name, input logic [8:0] idx, input bit border,
                             input logic [6:0] data, input bit opaque);
    bus.pix_en  = 1'b1;
    bus.hactive = 1'b1;
    tick();
    check({name, ".rdidx"}, 32'(bus.linebuf_rdidx), 32'(idx));
    bus.pix_en = 1'b0;
    tick();
    check({name, ".valid"},  32'(bus.pix_valid),  32'd1);
    check({name, ".border"}, 32'(bus.pix_border), 32'(border));
    check({name, ".data"},   32'(bus.pix_data),   32'(data));
    check({name, ".opaque"}, 32'(bus.pix_opaque), 32'(opaque));
    cur_col++;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 512; i++) lb_mem[i] = 7'h5A;
    lb_mem[0]   = 7'h35;
    lb_mem[1]   = 7'h30;
    lb_mem[100] = 7'h4B;
    lb_mem[319] = 7'h2C;

    //          nl vpos  st vline col  idx    bd data    op
    vecs[0]  = '{1, 9'd20,  1, 8'd1,   16,  9'd0,   0, 7'h35,  1};
    vecs[1]  = '{0, 9'd20,  0, 8'd0,   17,  9'd1,   0, 7'h30,  0};
    vecs[2]  = '{0, 9'd20,  0, 8'd0,   116, 9'd100, 0, 7'h4B,  1};
    vecs[3]  = '{0, 9'd20,  0, 8'd0,   335, 9'd319, 0, 7'h2C,  1};
    vecs[4]  = '{0, 9'd20,  0, 8'd0,   336, 9'd320, 1, BORDER, 0};
    vecs[5]  = '{1, 9'd21,  1, 8'd2,   15,  9'd511, 1, BORDER, 0};
    vecs[6]  = '{0, 9'd21,  0, 8'd0,   16,  9'd0,   0, 7'h35,  1};
    vecs[7]  = '{1, 9'd218, 1, 8'd199, 16,  9'd0,   0, 7'h35,  1};
    vecs[8]  = '{1, 9'd219, 0, 8'd199, 16,  9'd0,   0, 7'h35,  1};
    vecs[9]  = '{1, 9'd220, 0, 8'd199, 16,  9'd0,   1, BORDER, 0};
    vecs[10] = '{1, 9'd221, 0, 8'd199, 17,  9'd1,   1, BORDER, 0};

    reset          = 1'b1;
    bus.pix_en     = 1'b0;
    bus.line_start = 1'b0;
    bus.vpos       = 9'd0;
    bus.hactive    = 1'b0;
`ifdef GFX_SCANOUT_BORDER_EN
    bus.border_color = 7'h12;
`endif
    tick();
    tick();
    check("reset.start",     32'(bus.start),         32'd0);
    check("reset.vline",     32'(bus.vline),         32'd0);
    check("reset.rdidx",     32'(bus.linebuf_rdidx), 32'd0);
    check("reset.pix_valid", 32'(bus.pix_valid),     32'd0);
    check("reset.pix_data",  32'(bus.pix_data),      32'd0);
    reset = 1'b0;
    tick();

    do_line(9'd18, 1'b0, 8'd0);
    do_line(9'd19, 1'b1, 8'd0);

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].new_line) do_line(vecs[i].vpos, vecs[i].exp_start, vecs[i].exp_vline);
      advance(vecs[i].col - cur_col);
      cur_col = vecs[i].col;
      pixel_check($sformatf("vec%0d", i), vecs[i].exp_idx, vecs[i].exp_border,
                  vecs[i].exp_data, vecs[i].exp_opaque);
    end

    // pix_en without hactive: no output and no column advance (col stays 18).
    bus.pix_en  = 1'b1;
    bus.hactive = 1'b0;
    tick();
    bus.pix_en = 1'b0;
    tick();
    check("noact.valid", 32'(bus.pix_valid), 32'd0);
    tick();
    check("idle.valid",  32'(bus.pix_valid), 32'd0);
    pixel_check("after_noact", 9'd2, 1'b1, BORDER, 1'b0);

    // line_start together with pix_en: pixel sampled at column 0.
    bus.line_start = 1'b1;
    bus.vpos       = 9'd30;
    bus.pix_en     = 1'b1;
    bus.hactive    = 1'b1;
    tick();
    check("coinc.rdidx", 32'(bus.linebuf_rdidx), 32'd496);
    check("coinc.start", 32'(bus.start),         32'd1);
    check("coinc.vline", 32'(bus.vline),         32'd11);
    bus.line_start = 1'b0;
    bus.pix_en     = 1'b0;
    tick();
    check("coinc.valid",  32'(bus.pix_valid),  32'd1);
    check("coinc.border", 32'(bus.pix_border), 32'd1);

    // Reset mid-line 100 with a pixel in flight.
    do_line(9'd99,  1'b1, 8'd80);
    do_line(9'd100, 1'b1, 8'd81);
    advance(16);
    bus.pix_en  = 1'b1;
    bus.hactive = 1'b1;
    tick();
    bus.pix_en = 1'b0;
    reset      = 1'b1;
    tick();
    check("mid_rst.start",  32'(bus.start),         32'd0);
    check("mid_rst.vline",  32'(bus.vline),         32'd0);
    check("mid_rst.rdidx",  32'(bus.linebuf_rdidx), 32'd0);
    check("mid_rst.valid",  32'(bus.pix_valid),     32'd0);
    check("mid_rst.data",   32'(bus.pix_data),      32'd0);
    check("mid_rst.border", 32'(bus.pix_border),    32'd0);
    check("mid_rst.opaque", 32'(bus.pix_opaque),    32'd0);
    reset = 1'b0;
    tick();
    check("mid_rst.flush", 32'(bus.pix_valid), 32'd0);

    do_line(9'd101, 1'b1, 8'd82);
    advance(16);
    pixel_check("line101", 9'd0, 1'b1, BORDER, 1'b0);
    do_line(9'd102, 1'b1, 8'd83);
    advance(16);
    pixel_check("line102", 9'd0, 1'b0, 7'h35, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
